muldiv_ex_unit: RTL



---
 rtl/muldiv_ex_unit.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_ex_unit.sv
// RV32M multiply/divide EX unit: restoring divider with quotient/remainder operand cache.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier; otherwise multiplies iterate shift-add.
module muldiv_ex_unit #(
  parameter int XLEN     = 32,
  parameter int DIV_BITS = 1
) (
  input  logic            clk,
  input  logic            rst_pipe,
  input  logic            start_ex,
  input  logic [2:0]      muldiv_code_ex,
  input  logic [XLEN-1:0] rs1_sel,
  input  logic [XLEN-1:0] rs2_sel,
  input  logic [4:0]      rd_adr_ex,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_adr_done
);
  localparam int CW = $clog2(XLEN + 1);
  localparam int K  = XLEN / DIV_BITS;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [1:0]      code_q;
  logic            neg_q, rneg_q;
  logic [XLEN-1:0] rs1_q, rs2_q;
  logic [XLEN-1:0] acc_q, sh_q, opd_q;
  logic            c_valid, c_signed, c_is_rem;
  logic [XLEN-1:0] c_rs1, c_rs2, c_quo, c_rem;

  logic            is_div, div_signed, a_neg, b_neg;
  logic            div_zero, div_ovf, c_hit, div_short;
  logic [XLEN-1:0] abs_a, abs_b, sq, sr;

  always_comb begin
    is_div     = muldiv_code_ex[2];
    div_signed = ~muldiv_code_ex[0];
    if (is_div) begin
      a_neg = div_signed & rs1_sel[XLEN-1];
      b_neg = div_signed & rs2_sel[XLEN-1];
    end else begin
      // MULH and MULHSU take rs1 signed; only MULH takes rs2 signed
      a_neg = (muldiv_code_ex[1] ^ muldiv_code_ex[0]) & rs1_sel[XLEN-1];
      b_neg = (muldiv_code_ex[1:0] == 2'b01) & rs2_sel[XLEN-1];
    end
    abs_a    = a_neg ? -rs1_sel : rs1_sel;
    abs_b    = b_neg ? -rs2_sel : rs2_sel;
    div_zero = (rs2_sel == '0);
    div_ovf  = div_signed & (rs1_sel == MOST_NEG) & (rs2_sel == '1);
    c_hit    = c_valid & (c_rs1 == rs1_sel) & (c_rs2 == rs2_sel) &
               (c_signed == div_signed) & (c_is_rem != muldiv_code_ex[1]);
    sq = c_quo;
    sr = c_rem;
    if (div_zero) begin
      sq = '1;
      sr = rs1_sel;
    end else if (div_ovf) begin
      sq = MOST_NEG;
      sr = '0;
    end
    div_short = div_zero | div_ovf | c_hit;
  end

  logic [XLEN-1:0] d_rem, d_quo, d_fq, d_fr;
  logic [XLEN:0]   d_trial;

  always_comb begin
    d_rem   = acc_q;
    d_quo   = sh_q;
    d_trial = '0;
    for (int unsigned i = 0; i < DIV_BITS; i++) begin
      d_trial = {d_rem, d_quo[XLEN-1]} - {1'b0, opd_q};
      if (d_trial[XLEN])
        d_rem = {d_rem[XLEN-2:0], d_quo[XLEN-1]};
      else
        d_rem = d_trial[XLEN-1:0];
      d_quo = {d_quo[XLEN-2:0], ~d_trial[XLEN]};
    end
    d_fq = neg_q  ? -d_quo : d_quo;
    d_fr = rneg_q ? -d_rem : d_rem;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN+1:0] f_prod;
  logic [XLEN-1:0]          f_res;

  always_comb begin
    f_prod = $signed({a_neg, rs1_sel}) * $signed({b_neg, rs2_sel});
    f_res  = (muldiv_code_ex[1:0] == 2'b00) ? f_prod[XLEN-1:0] : f_prod[2*XLEN-1:XLEN];
  end
`else
  logic [XLEN:0]     m_sum;
  logic [2*XLEN-1:0] m_prod, m_fin;
  logic [XLEN-1:0]   m_res;

  // acc_q:sh_q is the running product; the multiplier drains out of sh_q's low end
  always_comb begin
    m_sum  = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opd_q} : '0);
    m_prod = {m_sum, sh_q[XLEN-1:1]};
    m_fin  = neg_q ? -m_prod : m_prod;
    m_res  = (code_q == 2'b00) ? m_fin[XLEN-1:0] : m_fin[2*XLEN-1:XLEN];
  end
`endif

  assign busy = ((state == IDLE) & start_ex & ~kill) | (state == MUL) | (state == DIV);

  always_ff @(posedge clk) begin
    if (rst_pipe) begin
      state       <= IDLE;
      done        <= 1'b0;
      result      <= '0;
      rd_adr_done <= '0;
      cnt         <= '0;
      code_q      <= '0;
      neg_q       <= 1'b0;
      rneg_q      <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      acc_q       <= '0;
      sh_q        <= '0;
      opd_q       <= '0;
      c_valid     <= 1'b0;
      c_signed    <= 1'b0;
      c_is_rem    <= 1'b0;
      c_rs1       <= '0;
      c_rs2       <= '0;
      c_quo       <= '0;
      c_rem       <= '0;
    end else if (kill) begin
      state   <= IDLE;
      done    <= 1'b0;
      c_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ex) begin
            code_q      <= muldiv_code_ex[1:0];
            rs1_q       <= rs1_sel;
            rs2_q       <= rs2_sel;
            rd_adr_done <= rd_adr_ex;
            neg_q       <= a_neg ^ b_neg;
            rneg_q      <= a_neg;
            cnt         <= '0;
            acc_q       <= '0;
            if (is_div) begin
              sh_q  <= abs_a;
              opd_q <= abs_b;
              if (div_short) begin
                result   <= muldiv_code_ex[1] ? sr : sq;
                c_valid  <= 1'b1;
                c_rs1    <= rs1_sel;
                c_rs2    <= rs2_sel;
                c_signed <= div_signed;
                c_is_rem <= muldiv_code_ex[1];
                c_quo    <= sq;
                c_rem    <= sr;
                done     <= 1'b1;
                state    <= FIN;
              end else begin
                state <= DIV;
              end
            end else begin
`ifdef MULDIV_FAST_MUL_EN
              result <= f_res;
              done   <= 1'b1;
              state  <= FIN;
`else
              sh_q  <= abs_b;
              opd_q <= abs_a;
              state <= MUL;
`endif
            end
          end
        end
        DIV: begin
          acc_q <= d_rem;
          sh_q  <= d_quo;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(K - 1)) begin
            result   <= code_q[1] ? d_fr : d_fq;
            c_valid  <= 1'b1;
            c_rs1    <= rs1_q;
            c_rs2    <= rs2_q;
            c_signed <= ~code_q[0];
            c_is_rem <= code_q[1];
            c_quo    <= d_fq;
            c_rem    <= d_fr;
            done     <= 1'b1;
            state    <= FIN;
          end
        end
`ifndef MULDIV_FAST_MUL_EN
        MUL: begin
          acc_q <= m_prod[2*XLEN-1:XLEN];
          sh_q  <= m_prod[XLEN-1:0];
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(XLEN - 1)) begin
            result <= m_res;
            done   <= 1'b1;
            state  <= FIN;
          end
        end
`endif
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
